// File: rtl/fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fir_seq_ctrl
// Moore sequencing controller for a 4-tap FIR datapath built around a
// 16-entry register file and one shared ALU.
//   R0      accumulator          R1..R4  sample window (R1 oldest)
//   R5      newly loaded sample  R6..R9  coefficients F0..F3
//   R10     product scratch
//
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   dr        in   data ready: new sample on the datapath load input
//   lc        in   load coefficient, one-cycle pulse per coefficient
//   overflow  in   ALU overflow for the op currently being issued
//   op        out  ALU opcode (NOP/COPY/LOAD1/LOAD2/ADD/SUB/MUL)
//   src1      out  ALU operand 1 register
//   src2      out  ALU operand 2 register
//   dest      out  ALU destination register
//   cnt_up    out  one-cycle sample-counter increment
//   clear     out  one-cycle sample-counter clear
//   modwait   out  controller busy
//   err       out  error status, held while parked in EIDLE
//
// Handshake: upstream may raise dr or lc only while modwait=0. The request
// is taken on the rising edge where it is seen in a resting state (IDLE,
// EIDLE, or WAITFn for lc). dr must stay high through the following STORE
// cycle; requests arriving while modwait=1 are ignored.
// ---------------------------------------------------------------------------
module fir_seq_ctrl #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              dr,
  input  logic              lc,
  input  logic              overflow,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] src1,
  output logic [ADDR_W-1:0] src2,
  output logic [ADDR_W-1:0] dest,
  output logic              cnt_up,
  output logic              clear,
  output logic              modwait,
  output logic              err
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_COPY  = 3'b001;
  localparam logic [2:0] OP_LOAD1 = 3'b010;
  localparam logic [2:0] OP_LOAD2 = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_LOADF0 = 5'd1,
    S_LOADF1 = 5'd2,
    S_LOADF2 = 5'd3,
    S_LOADF3 = 5'd4,
    S_WAITF1 = 5'd5,
    S_WAITF2 = 5'd6,
    S_WAITF3 = 5'd7,
    S_STORE  = 5'd8,
    S_ZERO   = 5'd9,
    S_SORT1  = 5'd10,
    S_SORT2  = 5'd11,
    S_SORT3  = 5'd12,
    S_SORT4  = 5'd13,
    S_MUL1   = 5'd14,
    S_ADD1   = 5'd15,
    S_MUL2   = 5'd16,
    S_SUB2   = 5'd17,
    S_MUL3   = 5'd18,
    S_ADD3   = 5'd19,
    S_MUL4   = 5'd20,
    S_SUB4   = 5'd21,
    S_EIDLE  = 5'd22
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic. Accumulate states divert to EIDLE on overflow; the
  // bad result already written to R0 is left in place.
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE, S_EIDLE: begin
        if (lc)      w_next = S_LOADF0;   // lc wins over dr
        else if (dr) w_next = S_STORE;
        else         w_next = r_state;
      end
      S_LOADF0: w_next = S_WAITF1;
      S_LOADF1: w_next = S_WAITF2;
      S_LOADF2: w_next = S_WAITF3;
      S_LOADF3: w_next = S_IDLE;
      S_WAITF1: w_next = lc ? S_LOADF1 : S_WAITF1;
      S_WAITF2: w_next = lc ? S_LOADF2 : S_WAITF2;
      S_WAITF3: w_next = lc ? S_LOADF3 : S_WAITF3;
      // dr must still be high here; a dropped dr is a protocol error
      S_STORE:  w_next = dr ? S_ZERO : S_EIDLE;
      S_ZERO:   w_next = S_SORT1;
      S_SORT1:  w_next = S_SORT2;
      S_SORT2:  w_next = S_SORT3;
      S_SORT3:  w_next = S_SORT4;
      S_SORT4:  w_next = S_MUL1;
      S_MUL1:   w_next = S_ADD1;
      S_ADD1:   w_next = overflow ? S_EIDLE : S_MUL2;
      S_MUL2:   w_next = S_SUB2;
      S_SUB2:   w_next = overflow ? S_EIDLE : S_MUL3;
      S_MUL3:   w_next = S_ADD3;
      S_ADD3:   w_next = overflow ? S_EIDLE : S_MUL4;
      S_MUL4:   w_next = S_SUB4;
      S_SUB4:   w_next = overflow ? S_EIDLE : S_IDLE;
      default:  w_next = S_IDLE;          // unused encodings recover
    endcase
  end

  // Output decode: purely a function of the state register.
  always_comb begin
    op      = OP_NOP;
    src1    = '0;
    src2    = '0;
    dest    = '0;
    cnt_up  = 1'b0;
    clear   = 1'b0;
    modwait = 1'b0;
    err     = 1'b0;
    case (r_state)
      S_LOADF0: begin op = OP_LOAD2; dest = ADDR_W'(6); modwait = 1'b1; clear = 1'b1; end
      S_LOADF1: begin op = OP_LOAD2; dest = ADDR_W'(7); modwait = 1'b1; end
      S_LOADF2: begin op = OP_LOAD2; dest = ADDR_W'(8); modwait = 1'b1; end
      S_LOADF3: begin op = OP_LOAD2; dest = ADDR_W'(9); modwait = 1'b1; end
      S_STORE:  begin op = OP_LOAD1; dest = ADDR_W'(5); modwait = 1'b1; end
      // R0 - R0 clears the accumulator without a dedicated opcode
      S_ZERO:   begin op = OP_SUB; cnt_up = 1'b1; modwait = 1'b1; end
      S_SORT1:  begin op = OP_COPY; src1 = ADDR_W'(2); dest = ADDR_W'(1); modwait = 1'b1; end
      S_SORT2:  begin op = OP_COPY; src1 = ADDR_W'(3); dest = ADDR_W'(2); modwait = 1'b1; end
      S_SORT3:  begin op = OP_COPY; src1 = ADDR_W'(4); dest = ADDR_W'(3); modwait = 1'b1; end
      S_SORT4:  begin op = OP_COPY; src1 = ADDR_W'(5); dest = ADDR_W'(4); modwait = 1'b1; end
      S_MUL1: begin
        op = OP_MUL; src1 = ADDR_W'(1); src2 = ADDR_W'(9); dest = ADDR_W'(10); modwait = 1'b1;
      end
      S_MUL2: begin
        op = OP_MUL; src1 = ADDR_W'(2); src2 = ADDR_W'(8); dest = ADDR_W'(10); modwait = 1'b1;
      end
      S_MUL3: begin
        op = OP_MUL; src1 = ADDR_W'(3); src2 = ADDR_W'(7); dest = ADDR_W'(10); modwait = 1'b1;
      end
      S_MUL4: begin
        op = OP_MUL; src1 = ADDR_W'(4); src2 = ADDR_W'(6); dest = ADDR_W'(10); modwait = 1'b1;
      end
      S_ADD1, S_ADD3: begin
        op = OP_ADD; src2 = ADDR_W'(10); modwait = 1'b1;
      end
      S_SUB2, S_SUB4: begin
        op = OP_SUB; src2 = ADDR_W'(10); modwait = 1'b1;
      end
      S_EIDLE:  err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fir_seq_ctrl
// Drives coefficient loads and samples into fir_seq_ctrl. Each transaction
// pushes the control words it should produce into exp_q; a monitor pops one
// entry whenever the controller shows a non-zero control word. A small
// register-file/ALU model executes the issued ops so the accumulator can be
// compared with the FIR sum computed directly from the sample history.
// ---------------------------------------------------------------------------
module tb_fir_seq_ctrl;
  localparam int AW = 4;
  localparam int W  = 19;   // {op, src1, src2, dest, cnt_up, clear, modwait, err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst, dr, lc, overflow;
  logic [2:0]    op;
  logic [AW-1:0] src1, src2, dest;
  logic          cnt_up, clear, modwait, err;
  logic [W-1:0]  dut_word;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .dr(dr), .lc(lc), .overflow(overflow),
    .op(op), .src1(src1), .src2(src2), .dest(dest),
    .cnt_up(cnt_up), .clear(clear), .modwait(modwait), .err(err)
  );

  assign dut_word = {op, src1, src2, dest, cnt_up, clear, modwait, err};

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [W-1:0] exp_q[$];

  int dp_r[16];          // datapath register file model
  int sample_bus = 0;
  int coef_bus   = 0;
  int coef_m[4];         // coefficients F0..F3 as loaded
  int win_m[4];          // sample window, [0] oldest
  bit err_rest  = 1'b0;  // controller parked in EIDLE
  int coef_idx  = 0;     // next coefficient index expected

  function automatic logic [W-1:0] mk(int o, int s1, int s2, int d,
                                      bit cu, bit cl, bit mw, bit er);
    logic [W-1:0] v;
    v = {3'(o), 4'(s1), 4'(s2), 4'(d), cu, cl, mw, er};
    return v;
  endfunction

  task automatic check_word(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (dut_word != '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_ctrl: got %h expected none", dut_word);
      end else begin
        check_word("ctrl_word", dut_word, exp_q.pop_front());
      end
    end
  end

  // ---------------- datapath model ----------------
  always @(negedge clk) begin
    case (op)
      3'd1: dp_r[dest] <= dp_r[src1];
      3'd2: dp_r[dest] <= sample_bus;
      3'd3: dp_r[dest] <= coef_bus;
      3'd4: dp_r[dest] <= dp_r[src1] + dp_r[src2];
      3'd5: dp_r[dest] <= dp_r[src1] - dp_r[src2];
      3'd6: dp_r[dest] <= dp_r[src1] * dp_r[src2];
      default: ;
    endcase
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle for g cycles in a resting state. While parked in EIDLE the
  // controller shows err=1 for the current cycle plus every idle cycle.
  task automatic rest_gap(int g, bit noise_dr);
    if (err_rest) repeat (g + 1) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    repeat (g) begin
      dr = noise_dr ? 1'($urandom_range(0, 1)) : 1'b0;
      lc = 1'b0;
      overflow = 1'b0;
      tick();
    end
    dr = 1'b0;
  endtask

  task automatic do_load(int val, int g, bit with_dr);
    int n;
    n = coef_idx;
    rest_gap(g, coef_idx != 0);
    exp_q.push_back(mk(3, 0, 0, 6 + n, 0, n == 0, 1, 0));
    coef_bus = val;
    lc = 1'b1;
    dr = with_dr;
    tick();                         // request taken; LOADFn cycle
    lc = 1'b0;
    dr = with_dr ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();                         // now WAITF(n+1) or IDLE
    dr = 1'b0;
    coef_m[n] = val;
    coef_idx  = (n + 1) % 4;
    err_rest  = 1'b0;
  endtask

  // mode: 0 normal, 1 overflow at accumulate step sel (1..4),
  //       2 dr dropped during STORE, 3 async reset during MUL2
  task automatic do_sample(int val, int mode, int sel);
    logic [W-1:0] seq[$];
    int s_len;
    int ovf_t;
    int exp_r0;
    seq.push_back(mk(2, 0, 0, 5, 0, 0, 1, 0));                    // STORE
    seq.push_back(mk(5, 0, 0, 0, 1, 0, 1, 0));                    // ZERO
    for (int i = 1; i <= 4; i++) seq.push_back(mk(1, i + 1, 0, i, 0, 0, 1, 0));
    for (int i = 1; i <= 4; i++) begin
      seq.push_back(mk(6, i, 10 - i, 10, 0, 0, 1, 0));
      seq.push_back(mk((i % 2 == 1) ? 4 : 5, 0, 10, 0, 0, 0, 1, 0));
    end
    case (mode)
      1:       s_len = 6 + 2 * sel;
      2:       s_len = 1;
      3:       s_len = 9;
      default: s_len = 14;
    endcase
    ovf_t = (mode == 1) ? 6 + 2 * sel : 0;
    rest_gap($urandom_range(0, 3), 1'b0);
    for (int i = 0; i < s_len; i++) exp_q.push_back(seq[i]);

    sample_bus = val;
    dr = 1'b1;
    lc = 1'b0;
    tick();                         // accepted; cycle t=1 is STORE
    for (int t = 1; t <= s_len; t++) begin
      dr = (t == 1) ? (mode != 2) : 1'($urandom_range(0, 1));
      lc = ($urandom_range(0, 3) == 0);
      if (t == ovf_t)                                   overflow = 1'b1;
      else if (t == 8 || t == 10 || t == 12 || t == 14) overflow = 1'b0;
      else                                              overflow = 1'($urandom_range(0, 1));
      if (mode == 3 && t == s_len) begin
        #5;
        n_rst = 1'b0;
        #1;
        check_word("reset_mid_seq", dut_word, '0);
        dr = 1'b0; lc = 1'b0; overflow = 1'b0;
        tick();
        n_rst = 1'b1;
        repeat (2) begin
          tick();
          check_word("idle_after_reset", dut_word, '0);
        end
      end else begin
        tick();
      end
    end
    dr = 1'b0; lc = 1'b0; overflow = 1'b0;

    if (s_len >= 6) begin           // window shift happened
      for (int i = 0; i < 3; i++) win_m[i] = win_m[i + 1];
      win_m[3] = val;
    end
    err_rest = (mode == 1 || mode == 2);
    if (mode == 0) begin
      exp_r0 = win_m[0] * coef_m[3] - win_m[1] * coef_m[2]
             + win_m[2] * coef_m[1] - win_m[3] * coef_m[0];
      check_int("acc_r0", dp_r[0], exp_r0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    n_rst = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
    for (int i = 0; i < 16; i++) dp_r[i] = 0;
    for (int i = 0; i < 4; i++) begin coef_m[i] = 0; win_m[i] = 0; end
    #12;
    check_word("reset_values", dut_word, '0);
    tick();
    n_rst = 1'b1;
    tick();
    check_word("idle_after_release", dut_word, '0);

    // directed: F={1,2,3,4}, samples 10,20,30,40 -> final R0 = 0
    for (int i = 0; i < 4; i++) do_load(i + 1, 3, 1'b0);
    do_sample(10, 0, 0);
    do_sample(20, 0, 0);
    do_sample(30, 0, 0);
    do_sample(40, 0, 0);
    check_int("fir_directed_zero", dp_r[0], 0);
    do_sample(50, 1, 2);            // overflow in SUB2 -> EIDLE
    do_sample(60, 0, 0);            // err clears on STORE
    do_sample(70, 2, 0);            // dropped dr
    do_sample(80, 0, 0);
    do_load(5, 2, 1'b1);            // lc and dr together: load wins
    for (int i = 1; i < 4; i++) do_load(5 + i, 2, 1'b1);
    do_sample(90, 3, 0);            // reset during MUL2
    do_sample(15, 0, 0);

    // randomized
    for (int n = 0; n < 60; n++) begin
      if (coef_idx != 0) begin
        do_load($urandom_range(0, 15), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      end else begin
        r = $urandom_range(0, 9);
        if (r <= 1)      do_load($urandom_range(0, 15), $urandom_range(0, 4), r == 1);
        else if (r <= 5) do_sample($urandom_range(0, 255), 0, 0);
        else if (r <= 7) do_sample($urandom_range(0, 255), 1, $urandom_range(1, 4));
        else if (r == 8) do_sample($urandom_range(0, 255), 2, 0);
        else             do_sample($urandom_range(0, 255), 3, 0);
      end
    end
    while (coef_idx != 0) do_load($urandom_range(0, 15), 1, 1'b0);

    rest_gap(3, 1'b0);
    #5;
    check_int("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Moore-style sequencing controller for the 4-tap FIR datapath: register file R0..R15, shared ALU with op/src1/src2/dest controls, overflow flag.
- Loads four coefficients, then for each incoming sample shifts the sample window and runs the multiply/accumulate schedule into R0.
- Downstream logic converts R0 to a 16-bit unsigned magnitude.
- Also drives the sample counter (cnt_up, clear) and the modwait/err status seen by the bus interface.

Parameters:
- ADDR_W, 4, register-file address width for src1/src2/dest (16 registers).

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- dr  input  1  data ready; new sample present on datapath load input
- lc  input  1  load coefficient; single-cycle pulse per coefficient
- overflow  input  1  ALU overflow, combinational from the current op
- op  output  3  ALU opcode: 000 NOP, 001 COPY, 010 LOAD1 (sample), 011 LOAD2 (coeff), 100 ADD, 101 SUB, 110 MUL
- src1  output  ADDR_W  ALU operand 1 register
- src2  output  ADDR_W  ALU operand 2 register
- dest  output  ADDR_W  ALU destination register
- cnt_up  output  1  one-cycle sample-counter increment
- clear  output  1  one-cycle sample-counter clear
- modwait  output  1  controller busy
- err  output  1  sticky error status

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low (n_rst), forcing state IDLE immediately, including mid-sequence.
- Outputs are pure decodes of the state register. Any output not listed for a state is 0.
- Reset values: op=000, src1=src2=dest=0, cnt_up=0, clear=0, modwait=0, err=0.
- Coefficient registers: R6=F0, R7=F1, R8=F2, R9=F3. Sample window: R1..R4 (R1 oldest). New sample lands in R5. Product scratch is R10. Accumulator is R0.

States (output; next):
- IDLE (all 0): lc=1 -> LOADF0, else dr=1 -> STORE. lc has priority when lc and dr are both high.
- LOADFn, n=0..3 (op=011, dest=6+n, modwait=1; LOADF0 also clear=1): LOADF0..2 -> WAITF(n+1); LOADF3 -> IDLE.
- WAITFn, n=1..3 (modwait=0): stays until lc=1, then -> LOADFn. dr is ignored here.
- STORE (op=010, dest=5, modwait=1): dr=0 -> EIDLE, else -> ZERO.
- ZERO (op=101, src1=0, src2=0, dest=0, cnt_up=1, modwait=1): -> SORT1.
- SORT1..SORT4 (op=001, modwait=1): R1<-R2, R2<-R3, R3<-R4, R4<-R5 in turn (src1=source, dest=target), then -> MUL1.
- MUL1 (op=110, R10<-R1*R9) -> ADD1 (op=100, R0<-R0+R10)
- ADD1 -> MUL2 (R10<-R2*R8) -> SUB2 (op=101, R0<-R0-R10)
- SUB2 -> MUL3 (R10<-R3*R7) -> ADD3
- ADD3 -> MUL4 (R10<-R4*R6) -> SUB4
- SUB4 -> IDLE. All MUL/ADD/SUB states have modwait=1.
- Overflow: in ADD1/SUB2/ADD3/SUB4, overflow=1 sampled at the clock edge -> EIDLE instead of the listed successor. The faulty result in R0 is not undone.
- EIDLE (err=1, modwait=0): lc=1 -> LOADF0, else dr=1 -> STORE. err clears on the first cycle of the new state.

Latency:
- dr high in IDLE at edge k: modwait is high from cycle k+1 through k+14 (14 busy states) and IDLE is re-entered at k+15.
- cnt_up pulses exactly once per accepted sample, at cycle k+2.

Boundaries:
- dr or lc asserted while modwait=1 is ignored; upstream must hold off.
- dr dropping during STORE is a protocol error -> EIDLE, and no cnt_up is issued.
- Unused or illegal state encodings -> IDLE.

Test Plan:
- Reset: n_rst low mid-MUL2 -> same cycle state IDLE, modwait=0, op=000, err=0. Release -> stays IDLE with dr=lc=0.
- Coefficient load: lc pulses at cycles 2, 6, 10, 14 -> LOAD2 to dest 6, 7, 8, 9 in order; clear=1 only at cycle 3; modwait=1 only on the four load cycles; ends in IDLE.
- Sample run: after loading F={1,2,3,4}, samples 10, 20, 30, 40 (dr held 2 cycles each) -> per sample exactly 14 busy cycles and one cnt_up. Sequence op=010,101,001×4,110,100,110,101,110,100,110,101. After the 4th sample, datapath R0 = 10·4 − 20·3 + 30·2 − 40·1 = 0.
- Overflow: force overflow=1 during SUB2 -> next state EIDLE, err=1, modwait=0. Next dr -> STORE with err=0.
- Dropped dr: dr high 1 cycle only -> STORE then EIDLE, err=1, no cnt_up.
- Simultaneous lc and dr in IDLE -> LOADF0 taken (op=011, dest=6); dr is ignored.
